dma_periph_endpoint: RTL

Peripheral-side DMA responder for the 8237A-style channel interface. It raises DREQ when its byte FIFO can source or sink data, and honours DACK_N with the IOR_N/IOW_N strobes issued by the DMA controller. It also sources data onto, or captures data from, the shared data bus, and terminates the block on EOP_N. It sits between an I/O device core (valid/ready byte streams) and one DMA channel (DREQn/DACKn pair) on the system bus.

---
 rtl/dma_periph_endpoint.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dma_periph_endpoint.sv
// rtl/dma_periph_endpoint.sv - 8237A-style DMA peripheral endpoint with byte FIFO
module dma_periph_endpoint #(
    parameter int FIFO_DEPTH = 8,
    parameter int DREQ_WM    = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        arm,
    input  logic        abort,
    input  logic        dir,
    output logic        DREQ,
    input  logic        DACK_N,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic        EOP_N,
    input  logic [7:0]  DB_IN,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic [15:0] byte_cnt,
    output logic        err_ovf,
    output logic        err_unf,
    output logic        err_proto
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, ACK, DONE} state_t;
    state_t state, next_state;

    logic          dir_q, ior_q, iow_q, dack_q, clash, eop_seen;
    logic [7:0]    db_in_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          empty, full, active, ack_low, both_low, wrong_dir, eop_set;
    logic          ior_xfer, iow_xfer, bus_pop, bus_push, ovf, unf;
    logic          loc_push, loc_pop, do_push, do_pop, req_cond;
    logic [7:0]    push_data;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign active = (state == ARMED) || (state == ACK);

    // A transfer is the strobe rising edge with DACK_N held low across it;
    // a cycle in which both strobes overlapped poisons the whole strobe pair.
    assign ack_low   = ~DACK_N & ~dack_q;
    assign ior_xfer  = (state == ACK) & ack_low & ~ior_q & IOR_N & ~clash & ~dir_q;
    assign iow_xfer  = (state == ACK) & ack_low & ~iow_q & IOW_N & ~clash & dir_q;
    assign both_low  = ~DACK_N & ~IOR_N & ~IOW_N;
    assign wrong_dir = (state == ACK) & ~DACK_N & (dir_q ? ~IOR_N : ~IOW_N);
    assign eop_set   = active & ~DACK_N & ~EOP_N;

    assign bus_pop  = ior_xfer & ~empty;
    assign unf      = ior_xfer & empty;
    assign bus_push = iow_xfer & ~full;
    assign ovf      = iow_xfer & full;

    assign wr_ready  = ~full & ~dir_q;
    assign rd_valid  = ~empty & dir_q;
    assign rd_data   = mem[rd_ptr];
    assign loc_push  = wr_valid & wr_ready;
    assign loc_pop   = rd_valid & rd_ready;
    assign do_push   = loc_push | bus_push;
    assign do_pop    = loc_pop | bus_pop;
    assign push_data = dir_q ? db_in_q : wr_data;

    assign DB_OUT = (~dir_q & ~empty) ? mem[rd_ptr] : 8'h00;
    assign DB_OE  = active & ~DACK_N & ~IOR_N & ~dir_q;
    assign done   = (state == DONE);

    assign req_cond = dir_q ? ((FIFO_DEPTH - int'(count)) >= DREQ_WM)
                            : (int'(count) >= DREQ_WM);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arm) next_state = ARMED;
            ARMED:   if (!DACK_N) next_state = ACK;
            ACK:     if (DACK_N) next_state = eop_seen ? DONE : ARMED;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (do_push && !abort) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            DREQ      <= 1'b0;
            dir_q     <= 1'b0;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            dack_q    <= 1'b1;
            clash     <= 1'b0;
            eop_seen  <= 1'b0;
            db_in_q   <= 8'h00;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            byte_cnt  <= 16'h0000;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state  <= next_state;
            ior_q  <= IOR_N;
            iow_q  <= IOW_N;
            dack_q <= DACK_N;
            DREQ   <= ~abort & active & (next_state != DONE) & req_cond;
            if (!IOW_N) db_in_q <= DB_IN;
            if (both_low) clash <= 1'b1;
            else if (IOR_N && IOW_N) clash <= 1'b0;

            if (abort) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                eop_seen  <= 1'b0;
                err_ovf   <= 1'b0;
                err_unf   <= 1'b0;
                err_proto <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                if (do_push && !do_pop)      count <= count + (AW+1)'(1);
                else if (do_pop && !do_push) count <= count - (AW+1)'(1);
                if (ior_xfer || iow_xfer) byte_cnt <= byte_cnt + 16'd1;

                if (state == IDLE && arm) begin
                    dir_q     <= dir;
                    byte_cnt  <= 16'h0000;
                    err_ovf   <= 1'b0;
                    err_unf   <= 1'b0;
                    err_proto <= 1'b0;
                    eop_seen  <= 1'b0;
                end else begin
                    if (ovf) err_ovf <= 1'b1;
                    if (unf) err_unf <= 1'b1;
                    if (both_low || wrong_dir) err_proto <= 1'b1;
                    if (state == DONE) eop_seen <= 1'b0;
                    else if (eop_set)  eop_seen <= 1'b1;
                end
            end
        end
    end
endmodule
